forwarding_hazard_unit: RTL and testbench

- Generates per-operand forwarding select and forwarding data for the two EX-stage operand muxes (1-bit selector plus 32-bit forwarding input per mux).
- Tracks the destination registers of the instructions in EX, MEM and WB using its own shadow pipeline.
- Detects load-use hazards in ID and asserts a one-cycle stall, inserting a bubble into EX.
- Sits between the decode stage and the EX operand muxes, alongside the ID/EX pipeline register.

---
 rtl/forwarding_hazard_unit.sv | 191 +++++++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// EX operand forwarding and load-use stall generation for a 5-stage pipeline.
// Keeps its own shadow copy of EX/MEM/WB destination info so no pipeline register taps are needed.

module fhu_fwd_operand #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_uses,
    input  logic [REG_AW-1:0] i_ex_src,
    input  logic              i_mem_valid,
    input  logic              i_mem_regwrite,
    input  logic              i_mem_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_wb_valid,
    input  logic              i_wb_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_sel,
    output logic [DATA_W-1:0] o_fwd
);
    logic w_reader;
    logic w_match_mem;
    logic w_match_wb;

    assign w_reader = i_ex_valid & i_ex_uses;

    // A load in MEM has no data yet; it is skipped so WB can still supply an older write.
    assign w_match_mem = w_reader & i_mem_valid & i_mem_regwrite & ~i_mem_memread
                       & (i_mem_rd != '0) & (i_mem_rd == i_ex_src);
    assign w_match_wb  = w_reader & i_wb_valid & i_wb_regwrite
                       & (i_wb_rd != '0) & (i_wb_rd == i_ex_src);

    always_comb begin
        o_sel = 1'b0;
        o_fwd = '0;
        if (w_match_mem) begin
            o_sel = 1'b1;
            o_fwd = i_mem_data;
        end else if (w_match_wb) begin
            o_sel = 1'b1;
            o_fwd = i_wb_data;
        end
    end
endmodule

module forwarding_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sel_a,
    output logic              sel_b,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    // Operand index 0 is rs (A), 1 is rt (B).
    typedef struct packed {
        stage_t                         dst;
        logic [NUM_OPS-1:0][REG_AW-1:0] src;
        logic [NUM_OPS-1:0]             uses;
    } ex_t;

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    ex_t    r_ex;
    stage_t r_mem;
    stage_t r_wb;
    state_t r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    ex_t                            w_ex_next;
    logic [NUM_OPS-1:0][REG_AW-1:0] w_id_src;
    logic [NUM_OPS-1:0]             w_id_uses;
    logic [NUM_OPS-1:0]             w_src_hit;
    logic                           w_hazard;
    logic                           w_stall;
    logic [NUM_OPS-1:0]             w_sel;
    logic [NUM_OPS-1:0][DATA_W-1:0] w_fwd;
    logic                           w_unused;

    assign w_id_src[0]  = id_rs;
    assign w_id_src[1]  = id_rt;
    assign w_id_uses[0] = id_uses_rs;
    assign w_id_uses[1] = id_uses_rt;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_hit
        assign w_src_hit[g] = w_id_uses[g] & (w_id_src[g] == r_ex.dst.rd);
    end

    assign w_hazard = id_valid & r_ex.dst.valid & r_ex.dst.memread & r_ex.dst.regwrite
                    & (r_ex.dst.rd != '0) & (|w_src_hit);
    assign w_stall  = w_hazard & ~flush;

    always_comb begin
        w_ex_next = '0;
        if (!(w_stall || flush || !id_valid)) begin
            w_ex_next.dst.valid    = 1'b1;
            w_ex_next.dst.rd       = id_rd;
            w_ex_next.dst.regwrite = id_regwrite;
            w_ex_next.dst.memread  = id_memread;
            w_ex_next.src          = w_id_src;
            w_ex_next.uses         = w_id_uses;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex.dst;
            r_ex  <= w_ex_next;
        end
    end

    // The bubble behind a load clears ex.memread, so a stall never lasts beyond one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN:   if (w_stall) r_state <= ST_STALL;
                ST_STALL: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_opnd
        fhu_fwd_operand #(
            .REG_AW (REG_AW),
            .DATA_W (DATA_W)
        ) u_fwd (
            .i_ex_valid     (r_ex.dst.valid),
            .i_ex_uses      (r_ex.uses[g]),
            .i_ex_src       (r_ex.src[g]),
            .i_mem_valid    (r_mem.valid),
            .i_mem_regwrite (r_mem.regwrite),
            .i_mem_memread  (r_mem.memread),
            .i_mem_rd       (r_mem.rd),
            .i_wb_valid     (r_wb.valid),
            .i_wb_regwrite  (r_wb.regwrite),
            .i_wb_rd        (r_wb.rd),
            .i_mem_data     (mem_alu_result),
            .i_wb_data      (wb_data),
            .o_sel          (w_sel[g]),
            .o_fwd          (w_fwd[g])
        );
    end

    // WB's load flag is tracked for completeness but the writeback value is already final.
    assign w_unused = r_wb.memread ^ (r_state == ST_STALL);

    assign sel_a       = w_sel[0];
    assign sel_b       = w_sel[1];
    assign fwd_a       = w_fwd[0];
    assign fwd_b       = w_fwd[1];
    assign stall       = w_stall;
    assign stall_count = r_stall_cnt;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboarded bench: a pipeline-history model predicts forwarding, stalls and stall counts.
// A second instance with a 2-bit counter exercises saturation within a short run.
module tb_forwarding_hazard_unit;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic [DW-1:0] mem_alu_result = '0, wb_data = '0;
    logic sel_a, sel_b, stall;
    logic [DW-1:0] fwd_a, fwd_b;
    logic [15:0] stall_count;
    logic s_sel_a, s_sel_b, s_stall;
    logic [DW-1:0] s_fwd_a, s_fwd_b;
    logic [1:0] s_stall_count;

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .mem_alu_result(mem_alu_result), .wb_data(wb_data),
        .sel_a(sel_a), .sel_b(sel_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .stall_count(stall_count));

    forwarding_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .mem_alu_result(mem_alu_result), .wb_data(wb_data),
        .sel_a(s_sel_a), .sel_b(s_sel_b), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall(s_stall), .stall_count(s_stall_count));

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int rd; bit rw; bit mr;
    } ins_t;

    typedef struct {
        bit sa; bit sb; logic [31:0] fa; logic [31:0] fb; bit st; int cnt; int scnt;
    } exp_t;

    int checks = 0;
    int fails = 0;
    exp_t q[$];

    // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, plus what ID held last cycle.
    ins_t pipe[3];
    ins_t last_id;
    bit last_stall, last_flush;
    int total_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr);
        ins_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rd = rd; r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        last_id = nop();
        last_stall = 0;
        last_flush = 0;
        total_stalls = 0;
    endtask

    task automatic model_advance();
        if (last_stall) total_stalls++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (last_stall || last_flush || !last_id.v) ? nop() : last_id;
    endtask

    // Newest older producer wins; a load still in MEM cannot supply data.
    task automatic model_fwd(input int src, input bit uses, input logic [31:0] md,
                             input logic [31:0] wd, output bit s, output logic [31:0] d);
        s = 0;
        d = 0;
        if (!pipe[0].v || !uses) return;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src) begin
                if (k == 1 && pipe[k].mr) begin
                    checks++;
                    fails++;
                    $display("FAIL load_in_mem_feeds_ex: reg %0d at %0t", src, $time);
                    continue;
                end
                s = 1;
                d = (k == 1) ? md : wd;
                return;
            end
        end
    endtask

    task automatic step(input ins_t in, input bit fl, input logic [31:0] md,
                        input logic [31:0] wd, output bit st);
        exp_t e;
        bit hz;
        @(posedge clk);
        model_advance();
        #1;
        id_valid = in.v; id_rs = in.rs[AW-1:0]; id_rt = in.rt[AW-1:0];
        id_uses_rs = in.urs; id_uses_rt = in.urt; id_rd = in.rd[AW-1:0];
        id_regwrite = in.rw; id_memread = in.mr; flush = fl;
        mem_alu_result = md; wb_data = wd;
        hz = in.v && pipe[0].v && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 &&
             ((in.urs && in.rs == pipe[0].rd) || (in.urt && in.rt == pipe[0].rd));
        st = hz && !fl;
        model_fwd(in.rs, 1'b0, md, wd, e.sa, e.fa);
        model_fwd(pipe[0].rs, pipe[0].urs, md, wd, e.sa, e.fa);
        model_fwd(pipe[0].rt, pipe[0].urt, md, wd, e.sb, e.fb);
        e.st = st;
        e.cnt = (total_stalls > 65535) ? 65535 : total_stalls;
        e.scnt = (total_stalls > 3) ? 3 : total_stalls;
        q.push_back(e);
        last_id = in;
        last_flush = fl;
        last_stall = st;
    endtask

    // A stalled ID instruction is presented again on the following cycle.
    task automatic issue(input ins_t in, input bit fl, input logic [31:0] md, input logic [31:0] wd);
        bit st;
        step(in, fl, md, wd, st);
        if (st) step(in, 1'b0, md, wd, st);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
        chk({tag, "_sel_b"}, 32'(sel_b), 32'd0);
        chk({tag, "_fwd_a"}, fwd_a, 32'd0);
        chk({tag, "_fwd_b"}, fwd_b, 32'd0);
        chk({tag, "_stall_count"}, 32'(stall_count), 32'd0);
        chk({tag, "_sat_count"}, 32'(s_stall_count), 32'd0);
    endtask

    bit prev_st = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_st = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("sel_a", 32'(sel_a), 32'(e.sa));
            chk("sel_b", 32'(sel_b), 32'(e.sb));
            chk("fwd_a", fwd_a, e.fa);
            chk("fwd_b", fwd_b, e.fb);
            chk("stall", 32'(stall), 32'(e.st));
            chk("stall_count", 32'(stall_count), 32'(e.cnt));
            chk("sat_stall_count", 32'(s_stall_count), 32'(e.scnt));
            chk("sat_stall", 32'(s_stall), 32'(e.st));
            chk("stall_back_to_back", 32'(stall && prev_st), 32'd0);
            prev_st = stall;
        end
    end

    initial begin
        bit st;
        ins_t r;
        logic [31:0] md, wd;
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // add r3,r1,r2 ; sub r5,r3,r4 with MEM value 0xAA
        md = 32'h0000_00AA; wd = 32'h5555_0000;
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, md, wd);
        issue(mk(1, 3, 4, 1, 1, 5, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // add r3 ; nop ; or r6,r7,r3 -> WB path
        md = 32'h0BAD_0000; wd = 32'h1234_5678;
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, md, wd);
        issue(nop(), 0, md, wd);
        issue(mk(1, 7, 3, 1, 1, 6, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // r3 written in both MEM and WB: MEM must win
        md = 32'hCAFE_0001;
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, md, wd);
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, md, wd);
        issue(mk(1, 7, 3, 1, 1, 6, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // lw r8,0(r1) ; add r9,r8,r8 -> one stall, then WB forwards 0xDEADBEEF on both
        wd = 32'hDEAD_BEEF;
        issue(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, md, wd);
        issue(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // same pair with flush on the consumer: no stall, bubble
        issue(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, md, wd);
        step(mk(1, 8, 8, 1, 1, 9, 1, 0), 1, md, wd, st);
        repeat (3) issue(nop(), 0, md, wd);

        // lw r0 ; add r1,r0,r0 -> nothing
        issue(mk(1, 1, 0, 1, 0, 0, 1, 1), 0, md, wd);
        issue(mk(1, 0, 0, 1, 1, 1, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // asynchronous reset in the middle of a stall cycle
        issue(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, md, wd);
        step(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, md, wd, st);
        chk("reset_stall_setup", 32'(st), 32'd1);
        #2;
        reset = 1'b1;
        q.delete();
        model_reset();
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        id_valid = 0; flush = 0;
        reset = 1'b0;

        // independent sequence after reset
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, md, wd);
        issue(mk(1, 4, 5, 1, 1, 6, 1, 0), 0, md, wd);
        issue(mk(1, 7, 8, 1, 1, 9, 1, 0), 0, md, wd);
        repeat (3) issue(nop(), 0, md, wd);

        // four back-to-back load-use pairs push the 2-bit counter past saturation
        for (int i = 0; i < 4; i++) begin
            issue(mk(1, 1, 0, 1, 0, 10 + i, 1, 1), 0, md, wd);
            issue(mk(1, 2, 10 + i, 1, 1, 20, 1, 0), 0, md, wd);
        end
        repeat (3) issue(nop(), 0, md, wd);

        for (int i = 0; i < 600; i++) begin
            r.v   = ($urandom_range(0, 9) != 0);
            r.rs  = $urandom_range(0, 3);
            r.rt  = $urandom_range(0, 3);
            r.urs = $urandom_range(0, 3) != 0;
            r.urt = $urandom_range(0, 1) != 0;
            r.rd  = $urandom_range(0, 3);
            r.mr  = $urandom_range(0, 2) == 0;
            r.rw  = r.mr || ($urandom_range(0, 4) != 0);
            issue(r, $urandom_range(0, 9) == 0, $urandom, $urandom);
        end
        repeat (3) issue(nop(), 0, md, wd);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
